// File: rtl/fp_matrix_mac.sv
// Sequential single-precision matrix multiply-accumulate: C = A*B or C += A*B,
// stepping every (i,j,k) through one shared multiplier and one shared adder.
module fp_matrix_mac #(
  parameter int M       = 2,
  parameter int N       = 2,
  parameter int P       = 2,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_mode,
  input  logic [M*N*32-1:0] a_in,
  input  logic [N*P*32-1:0] b_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [M*P*32-1:0] c_out
);

  localparam int IW   = (M > 1) ? $clog2(M) : 1;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int JW   = (P > 1) ? $clog2(P) : 1;
  localparam int LMAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int CW   = $clog2(LMAX + 1);
  localparam int AW   = $clog2(M*N*32);
  localparam int BW   = $clog2(N*P*32);
  localparam int OW   = $clog2(M*P*32);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Round-to-nearest-even; denormal inputs and results are flushed to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       pr;
    logic [22:0]       mt;
    logic              g, st;
    logic [23:0]       mr;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0)) return QNAN;
    if ((a[30:23] == 8'hff && b[30:23] == 0) || (b[30:23] == 8'hff && a[30:23] == 0)) return QNAN;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'd0};
    if (a[30:23] == 0 || b[30:23] == 0) return {s, 31'd0};
    pr = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
    if (pr[47]) begin
      mt = pr[46:24]; g = pr[23]; st = |pr[22:0]; e = e + 11'sd1;
    end else begin
      mt = pr[45:23]; g = pr[22]; st = |pr[21:0];
    end
    mr = {1'b0, mt} + 24'(g & (st | mt[0]));
    if (mr[23]) e = e + 11'sd1;
    if (e >= 11'sd255) return {s, 8'hff, 23'd0};
    if (e <= 11'sd0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [26:0]        mx, my;
    logic [53:0]        sh;
    logic [27:0]        sm;
    logic [25:0]        n;
    logic [4:0]         lz;
    logic               found;
    logic [23:0]        mr;
    logic signed [10:0] e;
    if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0)) return QNAN;
    if (a[30:23] == 8'hff && b[30:23] == 8'hff) return (a[31] != b[31]) ? QNAN : a;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:23] == 0 && b[30:23] == 0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 0) return b;
    if (b[30:23] == 0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b0};
    my = {1'b1, y[22:0], 3'b0};
    sh = {my, 27'd0} >> d;
    // Three extra low bits (guard/round/sticky) keep the alignment shift exact enough for RNE.
    if (d > 8'd26) my = 27'd1;
    else my = sh[53:27] | {26'd0, |sh[26:0]};
    e = $signed({3'b0, x[30:23]});
    if (x[31] == y[31]) begin
      sm = {1'b0, mx} + {1'b0, my};
      if (sm[27]) begin
        n = {sm[26:2], sm[1] | sm[0]}; e = e + 11'sd1;
      end else begin
        n = sm[25:0];
      end
    end else begin
      sm = {1'b0, mx} - {1'b0, my};
      if (sm == 0) return 32'd0;
      lz = '0; found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && sm[i]) begin lz = 5'(26 - i); found = 1'b1; end
      end
      sm = sm << lz;
      n  = sm[25:0];
      e  = e - $signed({6'd0, lz});
    end
    mr = {1'b0, n[25:3]} + 24'(n[2] & (n[1] | n[0] | n[3]));
    if (mr[23]) e = e + 11'sd1;
    if (e >= 11'sd255) return {x[31], 8'hff, 23'd0};
    if (e <= 11'sd0) return {x[31], 31'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_STORE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       i_q;
  logic [JW-1:0]       j_q;
  logic [KW-1:0]       k_q;
  logic [M*N*32-1:0]   a_q;
  logic [N*P*32-1:0]   b_q;
  logic                acc_q;
  logic [31:0]         prod_q, part_q;
  logic [M*P*32-1:0]   c_q;
  logic                done_q;

  logic                accept, mul_last, add_last, store_en, last_elem, last_k;
  logic [AW-1:0]       a_off;
  logic [BW-1:0]       b_off;
  logic [OW-1:0]       c_off;
  logic [31:0]         part_sel;

  always_comb begin
    a_off     = AW'((int'(i_q) * N + int'(k_q)) * 32);
    b_off     = BW'((int'(k_q) * P + int'(j_q)) * 32);
    c_off     = OW'((int'(i_q) * P + int'(j_q)) * 32);
    last_k    = (k_q == KW'(N - 1));
    last_elem = (i_q == IW'(M - 1)) && (j_q == JW'(P - 1));
    // At k=0 the running sum starts from +0.0, or from this element's C as held at accept.
    part_sel  = (k_q == '0) ? (acc_q ? c_q[c_off +: 32] : 32'd0) : part_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (cnt_q == CW'(MUL_LAT - 1)) state_d = S_ADD;
      S_ADD:   if (cnt_q == CW'(ADD_LAT - 1)) state_d = last_k ? S_STORE : S_MUL;
      S_STORE: state_d = last_elem ? S_DONE : S_MUL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and strobe logic
  always_comb begin
    ready    = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    done     = done_q;
    c_out    = c_q;
    accept   = (state_q == S_IDLE) && start;
    mul_last = (state_q == S_MUL) && (cnt_q == CW'(MUL_LAT - 1));
    add_last = (state_q == S_ADD) && (cnt_q == CW'(ADD_LAT - 1));
    store_en = (state_q == S_STORE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= 1'b0;
      prod_q <= '0;
      part_q <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      cnt_q  <= (mul_last || add_last || !(state_q == S_MUL || state_q == S_ADD)) ? '0 : cnt_q + CW'(1);
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        acc_q <= acc_mode;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
      end
      if (mul_last) prod_q <= fp_mul(a_q[a_off +: 32], b_q[b_off +: 32]);
      if (add_last) begin
        part_q <= fp_add(part_sel, prod_q);
        if (!last_k) k_q <= k_q + KW'(1);
      end
      if (store_en) begin
        c_q[c_off +: 32] <= part_q;
        k_q <= '0;
        if (j_q == JW'(P - 1)) begin
          j_q <= '0;
          i_q <= (i_q == IW'(M - 1)) ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + JW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_matrix_mac.sv
// Bench for fp_matrix_mac: a 2x2x2 instance and a 2x3x1 instance with longer latencies,
// checked against an integer-valued reference so every float result is exact.
module tb_fp_matrix_mac;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         start_s, acc_s, ready_s, busy_s, done_s;
  logic [127:0] a_s, b_s, c_s;
  logic         start_n, acc_n, ready_n, busy_n, done_n;
  logic [191:0] a_n;
  logic [95:0]  b_n;
  logic [63:0]  c_n;

  fp_matrix_mac u_sq (
    .clk(clk), .reset(rst_n), .start(start_s), .acc_mode(acc_s),
    .a_in(a_s), .b_in(b_s), .ready(ready_s), .busy(busy_s), .done(done_s), .c_out(c_s)
  );

  fp_matrix_mac #(.M(2), .N(3), .P(1), .MUL_LAT(2), .ADD_LAT(3)) u_ns (
    .clk(clk), .reset(rst_n), .start(start_n), .acc_mode(acc_n),
    .a_in(a_n), .b_in(b_n), .ready(ready_n), .busy(busy_n), .done(done_n), .c_out(c_n)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: integer matrices and the expected integer C of each instance.
  int ma [2][2];
  int mb [2][2];
  int mc [2][2];
  int na [2][3];
  int nb [3];
  int nc [2];

  logic [191:0] exp_q[$];

  function automatic logic [31:0] i2f(input int v);
    int m, e;
    logic [31:0] r;
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    e = 0;
    for (int t = 0; t < 31; t++) if ((m >> t) != 0) e = t;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'((m << (23 - e)) & 32'h007f_ffff);
    return r;
  endfunction

  function automatic int rnd_small();
    return int'($urandom_range(30)) - 15;
  endfunction

  function automatic logic [127:0] pack22(input int m [2][2]);
    logic [127:0] v;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) v[(r*2+c)*32 +: 32] = i2f(m[r][c]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_sq();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin ma[r][c] = rnd_small(); mb[r][c] = rnd_small(); end
  endtask

  // Driver: entered at a negedge; returns at the negedge one cycle after done.
  task automatic run_sq(input logic acc, input int inj_cyc, input bit chg, input string tag);
    int cyc, lat;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        mc[r][c] = (acc ? mc[r][c] : 0) + ma[r][0]*mb[0][c] + ma[r][1]*mb[1][c];
    exp_q.push_back(192'(pack22(mc)));
    a_s = pack22(ma); b_s = pack22(mb); acc_s = acc; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk({tag, "_busy"}, 192'(busy_s), 192'(1'b1));
    if (chg) begin
      a_s = {$urandom, $urandom, $urandom, $urandom};
      b_s = {$urandom, $urandom, $urandom, $urandom};
    end
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj_cyc) begin
        start_s = 1'b1; acc_s = ~acc;
        a_s = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start_s = 1'b0;
      end
      if (done_s) lat = cyc;
    end
    chk({tag, "_lat"}, 192'(lat), 192'(21));
    chk({tag, "_c"}, 192'(c_s), exp_q.pop_front());
    @(negedge clk);
    chk({tag, "_done_width"}, 192'(done_s), 192'(1'b0));
    chk({tag, "_ready"}, 192'(ready_s), 192'(1'b1));
  endtask

  task automatic run_ns(input logic acc, input string tag);
    int cyc, lat;
    for (int r = 0; r < 2; r++)
      nc[r] = (acc ? nc[r] : 0) + na[r][0]*nb[0] + na[r][1]*nb[1] + na[r][2]*nb[2];
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) a_n[(r*3+k)*32 +: 32] = i2f(na[r][k]);
    for (int k = 0; k < 3; k++) b_n[k*32 +: 32] = i2f(nb[k]);
    acc_n = acc; start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done_n) lat = cyc;
    end
    chk({tag, "_lat"}, 192'(lat), 192'(33));
    chk({tag, "_c"}, 192'(c_n), 192'({i2f(nc[1]), i2f(nc[0])}));
    @(negedge clk);
    chk({tag, "_done_width"}, 192'(done_n), 192'(1'b0));
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    start_s = 1'b0; acc_s = 1'b0; a_s = '0; b_s = '0;
    start_n = 1'b0; acc_n = 1'b0; a_n = '0; b_n = '0;
    mc = '{default: 0};
    nc = '{default: 0};
    repeat (3) @(negedge clk);
    chk("rst_c", 192'(c_s), 192'(0));
    chk("rst_ready", 192'(ready_s), 192'(1'b1));
    chk("rst_busy", 192'(busy_s), 192'(1'b0));
    chk("rst_done", 192'(done_s), 192'(1'b0));
    chk("rst_ns_c", 192'(c_n), 192'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 2x2 multiply, then the same run accumulated back-to-back
    ma = '{'{1, 2}, '{3, 4}};
    mb = '{'{2, 0}, '{0, 2}};
    run_sq(1'b0, -1, 1'b0, "sq_mul");
    chk("sq_mul_const", 192'(c_s), 192'(128'h41000000_40C00000_40800000_40000000));
    run_sq(1'b1, -1, 1'b0, "sq_acc");
    chk("sq_acc_const", 192'(c_s), 192'(128'h41800000_41400000_41000000_40800000));

    // Directed non-square
    na = '{'{1, 1, 1}, '{2, 2, 2}};
    nb = '{1, 2, 3};
    run_ns(1'b0, "ns_mul");
    chk("ns_const", 192'(c_n), 192'(64'h41400000_40C00000));

    // Start while busy, then a back-to-back random accumulate
    rand_sq();
    run_sq(1'b0, 5, 1'b0, "sq_busy_start");
    rand_sq();
    run_sq(1'b1, -1, 1'b0, "sq_b2b_acc");

    // Operands changed the cycle after accept
    rand_sq();
    run_sq(1'b0, -1, 1'b1, "sq_opchg");

    // Reset mid-run
    rand_sq();
    a_s = pack22(ma); b_s = pack22(mb); acc_s = 1'b0; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_c", 192'(c_s), 192'(0));
    chk("midrst_busy", 192'(busy_s), 192'(1'b0));
    chk("midrst_ready", 192'(ready_s), 192'(1'b1));
    rst_n = 1'b1;
    mc = '{default: 0};
    nc = '{default: 0};
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_s) nd++;
    end
    chk("midrst_no_done", 192'(nd), 192'(0));
    rand_sq();
    run_sq(1'b1, -1, 1'b0, "sq_after_rst");

    // Randomised runs on both instances
    for (int t = 0; t < 4; t++) begin
      rand_sq();
      run_sq(1'($urandom_range(1)), -1, 1'b0, "sq_rand");
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 3; k++) na[r][k] = rnd_small();
      for (int k = 0; k < 3; k++) nb[k] = rnd_small();
      run_ns(1'($urandom_range(1)), "ns_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
